// File: rtl/prim_alert_hs_monitor_pkg.sv
// Shared types and constants for the alert/ack handshake monitor.
package prim_alert_hs_monitor_pkg;

  typedef enum logic [2:0] {
    HsIdle    = 3'b000,
    HsAlertHi = 3'b001,
    HsAckHi   = 3'b010,
    HsAlertLo = 3'b011,
    HsErr     = 3'b100
  } hs_state_e;

  localparam int unsigned NumErrBits   = 3;
  localparam int unsigned ErrSigintIdx = 0;
  localparam int unsigned ErrTimingIdx = 1;
  localparam int unsigned ErrProtoIdx  = 2;

  // Clean cycles (both levels low, both pairs differential) needed to leave Err.
  localparam int unsigned ErrExitCycles = 2;

endpackage

// File: rtl/prim_alert_hs_chan.sv
// One monitored channel: differential decode, 4-phase handshake FSM,
// inter-edge timing counter and sticky error flags.
module prim_alert_hs_chan
  import prim_alert_hs_monitor_pkg::*;
#(
  parameter int unsigned MinHsCycles = 3,
  parameter int unsigned MaxHsCycles = 5,
  parameter int unsigned SkewCycles  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  alert_p_i,
  input  logic                  alert_n_i,
  input  logic                  ack_p_i,
  input  logic                  ack_n_i,
  output logic                  hs_done_o,
  output logic [NumErrBits-1:0] err_o,
  output logic                  busy_o
);

  localparam int unsigned CntW  = $clog2(MaxHsCycles + 2);
  localparam int unsigned SkewW = $clog2(SkewCycles + 2);

  localparam logic [CntW-1:0]  CntMin   = CntW'(MinHsCycles);
  localparam logic [CntW-1:0]  CntMax   = CntW'(MaxHsCycles);
  localparam logic [CntW-1:0]  CntSat   = CntW'(MaxHsCycles + 1);
  localparam logic [SkewW-1:0] SkewLim  = SkewW'(SkewCycles);
  localparam logic [SkewW-1:0] SkewSat  = SkewW'(SkewCycles + 1);
  localparam logic [1:0]       CleanSat = 2'(ErrExitCycles);

  hs_state_e             state_q, state_d, adv_state;
  logic                  alert_lvl_q, alert_lvl_d;
  logic                  ack_lvl_q, ack_lvl_d;
  logic [SkewW-1:0]      alert_skew_q, alert_skew_d;
  logic [SkewW-1:0]      ack_skew_q, ack_skew_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            clean_q, clean_d;
  logic                  hs_done_q, hs_done_d;
  logic [NumErrBits-1:0] err_q, err_d, err_set;

  logic alert_diff, ack_diff;
  logic alert_edge, ack_edge, any_edge;
  logic alert_rise, alert_fall, ack_rise, ack_fall;
  logic exp_edge, sigint, timing, proto, clean;

  assign alert_diff = alert_p_i ^ alert_n_i;
  assign ack_diff   = ack_p_i ^ ack_n_i;

  // p==n holds the last good level; the skew counter tracks how long.
  always_comb begin
    alert_lvl_d  = alert_diff ? alert_p_i : alert_lvl_q;
    ack_lvl_d    = ack_diff ? ack_p_i : ack_lvl_q;
    alert_skew_d = '0;
    ack_skew_d   = '0;
    if (en_i && !alert_diff) begin
      alert_skew_d = (alert_skew_q == SkewSat) ? SkewSat : alert_skew_q + SkewW'(1);
    end
    if (en_i && !ack_diff) begin
      ack_skew_d = (ack_skew_q == SkewSat) ? SkewSat : ack_skew_q + SkewW'(1);
    end
  end

  assign alert_edge = alert_lvl_d ^ alert_lvl_q;
  assign ack_edge   = ack_lvl_d ^ ack_lvl_q;
  assign any_edge   = alert_edge | ack_edge;
  assign alert_rise = alert_edge & alert_lvl_d;
  assign alert_fall = alert_edge & ~alert_lvl_d;
  assign ack_rise   = ack_edge & ack_lvl_d;
  assign ack_fall   = ack_edge & ~ack_lvl_d;
  assign sigint     = en_i & ((alert_skew_d > SkewLim) | (ack_skew_d > SkewLim));
  assign clean      = alert_diff & ack_diff & ~alert_lvl_d & ~ack_lvl_d;

  // The single edge each phase waits for; a simultaneous second edge disqualifies it.
  always_comb begin
    exp_edge  = 1'b0;
    adv_state = state_q;
    unique case (state_q)
      HsIdle: begin
        exp_edge  = alert_rise & ~ack_edge;
        adv_state = HsAlertHi;
      end
      HsAlertHi: begin
        exp_edge  = ack_rise & ~alert_edge;
        adv_state = HsAckHi;
      end
      HsAckHi: begin
        exp_edge  = alert_fall & ~ack_edge;
        adv_state = HsAlertLo;
      end
      HsAlertLo: begin
        exp_edge  = ack_fall & ~alert_edge;
        adv_state = HsIdle;
      end
      default: begin
        exp_edge  = 1'b0;
        adv_state = state_q;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hs_done_d = 1'b0;
    timing    = 1'b0;
    proto     = 1'b0;
    clean_d   = '0;
    cnt_d     = any_edge ? CntW'(1) :
                (cnt_q == CntSat) ? CntSat : cnt_q + CntW'(1);

    if (state_q == HsErr) begin
      if (clean) begin
        clean_d = (clean_q == CleanSat) ? CleanSat : clean_q + 2'd1;
      end
      if (clean_d == CleanSat) begin
        state_d = HsIdle;
      end
    end else if (exp_edge) begin
      if (state_q != HsIdle && (cnt_q < CntMin || cnt_q > CntMax)) begin
        timing = 1'b1;
      end else begin
        state_d   = adv_state;
        hs_done_d = (state_q == HsAlertLo);
      end
    end else if (any_edge) begin
      proto = 1'b1;
    end else if (state_q != HsIdle && cnt_q == CntSat) begin
      timing = 1'b1;
    end

    if (sigint || timing || proto) begin
      state_d   = HsErr;
      hs_done_d = 1'b0;
      clean_d   = '0;
    end

    // Disabled: silent abort, nothing new is flagged.
    if (!en_i) begin
      state_d   = HsIdle;
      cnt_d     = '0;
      clean_d   = '0;
      hs_done_d = 1'b0;
      timing    = 1'b0;
      proto     = 1'b0;
    end
  end

  always_comb begin
    err_set               = '0;
    err_set[ErrSigintIdx] = sigint;
    err_set[ErrTimingIdx] = timing;
    err_set[ErrProtoIdx]  = proto;
    err_d = err_set | (err_q & ~{NumErrBits{clr_i}});
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= HsIdle;
      alert_lvl_q  <= 1'b0;
      ack_lvl_q    <= 1'b0;
      alert_skew_q <= '0;
      ack_skew_q   <= '0;
      cnt_q        <= '0;
      clean_q      <= '0;
      hs_done_q    <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      alert_lvl_q  <= alert_lvl_d;
      ack_lvl_q    <= ack_lvl_d;
      alert_skew_q <= alert_skew_d;
      ack_skew_q   <= ack_skew_d;
      cnt_q        <= cnt_d;
      clean_q      <= clean_d;
      hs_done_q    <= hs_done_d;
      err_q        <= err_d;
    end
  end

  assign hs_done_o = hs_done_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != HsIdle);

endmodule

// File: rtl/prim_alert_hs_monitor.sv
// Observe-only runtime checker for NumAlerts alert/ack differential channels.
module prim_alert_hs_monitor
  import prim_alert_hs_monitor_pkg::*;
#(
  parameter int unsigned NumAlerts   = 4,
  parameter int unsigned MinHsCycles = 3,
  parameter int unsigned MaxHsCycles = 5,
  parameter int unsigned SkewCycles  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumAlerts-1:0] en_i,
  input  logic                 clr_i,
  input  logic [NumAlerts-1:0] alert_p_i,
  input  logic [NumAlerts-1:0] alert_n_i,
  input  logic [NumAlerts-1:0] ack_p_i,
  input  logic [NumAlerts-1:0] ack_n_i,
  output logic [NumAlerts-1:0] hs_done_o,
  output logic [NumAlerts-1:0] sigint_err_o,
  output logic [NumAlerts-1:0] timing_err_o,
  output logic [NumAlerts-1:0] proto_err_o,
  output logic [NumAlerts-1:0] busy_o
);

  logic [NumErrBits-1:0] chan_err [NumAlerts];

  for (genvar i = 0; i < NumAlerts; i++) begin : g_chan
    prim_alert_hs_chan #(
      .MinHsCycles(MinHsCycles),
      .MaxHsCycles(MaxHsCycles),
      .SkewCycles (SkewCycles)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (en_i[i]),
      .clr_i    (clr_i),
      .alert_p_i(alert_p_i[i]),
      .alert_n_i(alert_n_i[i]),
      .ack_p_i  (ack_p_i[i]),
      .ack_n_i  (ack_n_i[i]),
      .hs_done_o(hs_done_o[i]),
      .err_o    (chan_err[i]),
      .busy_o   (busy_o[i])
    );

    assign sigint_err_o[i] = chan_err[i][ErrSigintIdx];
    assign timing_err_o[i] = chan_err[i][ErrTimingIdx];
    assign proto_err_o[i]  = chan_err[i][ErrProtoIdx];
  end

endmodule

// File: tb/tb_prim_alert_hs_monitor.sv
// Scoreboard bench: each stimulus step queues the outputs expected after its sample edge.
module tb_prim_alert_hs_monitor;
  localparam int NA = 4;
  localparam int S_DONE = 0, S_SIG = 1, S_TIM = 2, S_PRO = 3, S_BUSY = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clr;
  logic [NA-1:0] en, alert_p, alert_n, ack_p, ack_n;
  logic [NA-1:0] hs_done, sigint_err, timing_err, proto_err, busy;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int            cyc;
    string         tag;
    int            sig;
    logic [NA-1:0] exp;
  } exp_t;
  exp_t sb[$];

  prim_alert_hs_monitor #(
    .NumAlerts(NA), .MinHsCycles(3), .MaxHsCycles(5), .SkewCycles(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr),
    .alert_p_i(alert_p), .alert_n_i(alert_n), .ack_p_i(ack_p), .ack_n_i(ack_n),
    .hs_done_o(hs_done), .sigint_err_o(sigint_err), .timing_err_o(timing_err),
    .proto_err_o(proto_err), .busy_o(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NA-1:0] obs(int s);
    case (s)
      S_DONE:  return hs_done;
      S_SIG:   return sigint_err;
      S_TIM:   return timing_err;
      S_PRO:   return proto_err;
      default: return busy;
    endcase
  endfunction

  // Compare everything due for this cycle, shortly after the edge.
  always @(posedge clk) begin
    #2;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, 32'(obs(sb[i].sig)), 32'(sb[i].exp));
        sb.delete(i);
      end
    end
  end

  // dly=0: outputs following the sample of the inputs driven right now.
  task automatic exp_at(int dly, string tag, int sig, logic [NA-1:0] v);
    exp_t e;
    e.cyc = cyc + 1 + dly;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic exp_quiet(string tag);
    exp_at(0, {tag, "_done"}, S_DONE, '0);
    exp_at(0, {tag, "_sig"},  S_SIG,  '0);
    exp_at(0, {tag, "_tim"},  S_TIM,  '0);
    exp_at(0, {tag, "_pro"},  S_PRO,  '0);
    exp_at(0, {tag, "_busy"}, S_BUSY, '0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_alert(int ch, logic v);
    alert_p[ch] = v;
    alert_n[ch] = ~v;
  endtask

  task automatic set_ack(int ch, logic v);
    ack_p[ch] = v;
    ack_n[ch] = ~v;
  endtask

  task automatic skew_alert(int ch, logic v);
    alert_p[ch] = v;
    alert_n[ch] = v;
  endtask

  task automatic legal_hs(int ch, int g1, int g2, int g3);
    int t;
    logic [NA-1:0] m;
    t = g1 + g2 + g3;
    m = NA'(1) << ch;
    for (int i = 0; i <= t; i++) begin
      if (i == 0)       set_alert(ch, 1'b1);
      if (i == g1)      set_ack(ch, 1'b1);
      if (i == g1 + g2) set_alert(ch, 1'b0);
      if (i == t)       set_ack(ch, 1'b0);
      exp_at(0, "hs_busy", S_BUSY, m & {NA{i < t}});
      exp_at(0, "hs_done", S_DONE, m & {NA{i == t}});
      exp_at(0, "hs_tim",  S_TIM,  '0);
      exp_at(0, "hs_pro",  S_PRO,  '0);
      tick();
    end
    exp_at(0, "hs_done_pulse", S_DONE, '0);
    exp_at(0, "hs_sig", S_SIG, '0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = '1;
    alert_p = '0; alert_n = '1; ack_p = '0; ack_n = '1;
    tick();
    tick();
    exp_quiet("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Legal handshakes: nominal gaps, then the Min/Max boundaries.
    legal_hs(0, 4, 4, 4);
    legal_hs(3, 3, 5, 3);

    // Timeout: ack never comes; expires when d reaches MaxHsCycles+1.
    set_alert(0, 1'b1);
    exp_at(0, "to_busy", S_BUSY, 4'b0001);
    tick();
    for (int i = 1; i <= 6; i++) begin
      exp_at(0, "to_tim", S_TIM, {3'b000, i == 6});
      tick();
    end
    set_alert(0, 1'b0);
    exp_at(0, "to_err_busy", S_BUSY, 4'b0001);
    tick();
    exp_at(0, "to_recover", S_BUSY, 4'b0000);
    exp_at(0, "to_sticky", S_TIM, 4'b0001);
    exp_at(0, "to_no_pro", S_PRO, 4'b0000);
    tick();
    clr = 1'b1;
    exp_at(0, "to_clr", S_TIM, 4'b0000);
    tick();
    clr = 1'b0;

    // Early ack on ch0 while ch1 completes a legal handshake.
    for (int i = 0; i <= 12; i++) begin
      case (i)
        0:  begin set_alert(0, 1'b1); set_alert(1, 1'b1); end
        2:  set_ack(0, 1'b1);
        3:  begin set_alert(0, 1'b0); set_ack(0, 1'b0); end
        4:  set_ack(1, 1'b1);
        8:  set_alert(1, 1'b0);
        12: set_ack(1, 1'b0);
        default: ;
      endcase
      if (i == 1) exp_at(0, "early_none", S_TIM, 4'b0000);
      if (i == 2) exp_at(0, "early_tim", S_TIM, 4'b0001);
      if (i == 3) exp_at(0, "early_busy", S_BUSY, 4'b0011);
      if (i == 4) exp_at(0, "early_recov", S_BUSY, 4'b0010);
      if (i == 12) begin
        exp_at(0, "early_done1", S_DONE, 4'b0010);
        exp_at(0, "early_idle", S_BUSY, 4'b0000);
        exp_at(0, "early_sticky", S_TIM, 4'b0001);
        exp_at(0, "early_pro", S_PRO, 4'b0000);
      end
      tick();
    end
    clr = 1'b1;
    exp_at(0, "early_done_off", S_DONE, 4'b0000);
    tick();
    clr = 1'b0;

    // Skew: one p==n cycle is tolerated, two are not.
    skew_alert(0, 1'b1);
    exp_at(0, "skew1", S_SIG, 4'b0000);
    tick();
    set_alert(0, 1'b0);
    exp_at(0, "skew1_clean", S_SIG, 4'b0000);
    tick();
    skew_alert(0, 1'b1);
    exp_at(0, "skew2a", S_SIG, 4'b0000);
    tick();
    exp_at(0, "skew2b", S_SIG, 4'b0001);
    exp_at(0, "skew_busy", S_BUSY, 4'b0001);
    tick();
    set_alert(0, 1'b0);
    exp_at(0, "skew_err_busy", S_BUSY, 4'b0001);
    tick();
    exp_at(0, "skew_recov", S_BUSY, 4'b0000);
    exp_at(0, "skew_sticky", S_SIG, 4'b0001);
    tick();
    clr = 1'b1;
    exp_at(0, "skew_clr", S_SIG, 4'b0000);
    tick();
    clr = 1'b0;

    // Protocol: ack in Idle on ch0, simultaneous edges on ch2, clr vs new error.
    set_ack(0, 1'b1); set_alert(2, 1'b1); set_ack(2, 1'b1);
    exp_at(0, "pro_set", S_PRO, 4'b0101);
    exp_at(0, "pro_busy", S_BUSY, 4'b0101);
    tick();
    set_ack(0, 1'b0); set_alert(2, 1'b0); set_ack(2, 1'b0);
    tick();
    exp_at(0, "pro_recov", S_BUSY, 4'b0000);
    exp_at(0, "pro_sticky", S_PRO, 4'b0101);
    tick();
    clr = 1'b1;
    exp_at(0, "pro_clr", S_PRO, 4'b0000);
    tick();
    set_ack(0, 1'b1);
    exp_at(0, "pro_set_wins", S_PRO, 4'b0001);
    tick();
    clr = 1'b0;
    set_ack(0, 1'b0);
    tick();
    exp_at(0, "pro_recov2", S_BUSY, 4'b0000);
    tick();
    clr = 1'b1;
    exp_at(0, "pro_clr2", S_PRO, 4'b0000);
    tick();
    clr = 1'b0;

    // en_i low mid-handshake aborts silently; skew while disabled is ignored.
    for (int i = 0; i <= 10; i++) begin
      case (i)
        0: set_alert(0, 1'b1);
        4: set_ack(0, 1'b1);
        5: en[0] = 1'b0;
        6: skew_alert(0, 1'b1);
        9: begin set_alert(0, 1'b0); set_ack(0, 1'b0); end
        10: en[0] = 1'b1;
        default: ;
      endcase
      if (i == 4) exp_at(0, "en_busy", S_BUSY, 4'b0001);
      if (i == 5) exp_quiet("en_abort");
      if (i == 8) exp_at(0, "en_skew", S_SIG, 4'b0000);
      if (i == 9) exp_quiet("en_edges");
      if (i == 10) exp_quiet("en_back");
      tick();
    end

    // Reset mid-handshake.
    set_alert(0, 1'b1);
    exp_at(0, "rst_hs_busy", S_BUSY, 4'b0001);
    tick();
    repeat (3) tick();
    set_ack(0, 1'b1);
    exp_at(0, "rst_hs_ack", S_BUSY, 4'b0001);
    tick();
    rst_n = 1'b0;
    exp_quiet("rst_mid");
    tick();
    set_alert(0, 1'b0); set_ack(0, 1'b0);
    tick();
    rst_n = 1'b1;
    exp_quiet("rst_rel");
    tick();
    exp_quiet("rst_after");
    tick();
    tick();

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
